bram_port_a_arbiter: RTL
========================

Name: bram_port_a_arbiter

Overview:
- Round-robin arbiter that shares port A of the byte-writable dual-port block RAM among NUM_REQ requesters.
- Issues at most one access per cycle to the RAM.
- Sequences the RAM's two-stage read path (array read register, then the enable/reset output register).
- Routes each read's data back to the requester that issued it, with fixed 2-cycle latency.
- Port B of the RAM is not touched by this block.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- NB_COL, 4, byte-write columns per word.
- COL_WIDTH, 8, bits per column.
- ADDR_BITS, 10, RAM word-address width.
- WORD_WIDTH, NB_COL*COL_WIDTH, data word width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  one-hot grant; a request is accepted when valid&ready.
- req_we_i  in  NUM_REQ*NB_COL  byte enables; all-zero means read, non-zero means write. Slice i belongs to requester i.
- req_addr_i  in  NUM_REQ*ADDR_BITS  word address per requester.
- req_wdata_i  in  NUM_REQ*WORD_WIDTH  write data per requester.
- rsp_valid_o  out  NUM_REQ  one-hot read-data valid.
- rsp_data_o  out  WORD_WIDTH  read data, shared by all requesters.
- ram_en_o  out  1  drives the RAM port A enable.
- ram_we_o  out  NB_COL  drives the RAM port A byte write enables.
- ram_addr_o  out  ADDR_BITS  drives the RAM port A address.
- ram_wdata_o  out  WORD_WIDTH  drives the RAM port A write data.
- ram_reg_en_o  out  1  drives the RAM output-register enable.
- ram_reg_rst_o  out  1  drives the RAM output-register reset (active-high).
- ram_rdata_i  in  WORD_WIDTH  taken from the RAM port A output.

Behaviour:
- Clocking and reset
  - One clock domain. Reset is synchronous, active-low, sampled on the clk_i rising edge.
  - ram_reg_rst_o = ~rst_ni, combinational.
- Arbitration (combinational)
  - Priority pointer ptr, width clog2(NUM_REQ).
  - Grant goes to the first i with req_valid_i[i]=1, searching ptr, ptr+1, … modulo NUM_REQ.
  - req_ready_o is one-hot on the winner, all-zero when no request is valid.
  - No requester is ever stalled by the RAM; a grant occurs every cycle some request is valid.
- RAM drive (combinational from the grant)
  - ram_en_o = |req_ready_o.
  - ram_we_o, ram_addr_o and ram_wdata_o are muxed from the winner's slices.
  - With no grant they are all zero.
- Pointer update
  - On a grant to i: ptr <= (i+1) mod NUM_REQ. Otherwise ptr holds.
  - Reset value is 0.
- Read pipeline (registered)
  - Stage 1: s1_valid, s1_id.
    - Loaded at the edge ending accept cycle T: valid = grant & (we==0), id = winner index.
    - ram_reg_en_o = s1_valid at T+1, which moves the RAM's array register into its output register.
  - Stage 2: s2_valid, s2_id, loaded from stage 1.
  - At T+2: rsp_valid_o = onehot(s2_id) gated by s2_valid, and rsp_data_o = ram_rdata_i.
  - Read latency is exactly 2 cycles, fully pipelined, one response per cycle maximum.
  - Responses cannot be backpressured; requesters must accept them.
- Writes
  - Take effect at the accept edge and produce no response.
  - A partial we writes only the enabled columns.
- Ordering and hazards
  - Read accepted at T+1 after a write at T to the same address returns the new data.
  - A single access is either read or write, so a read is never issued in the same cycle as a write.
  - Responses return in accept order.
- Reset outputs
  - ptr=0, s1_valid=s2_valid=0.
  - rsp_valid_o=0, ram_reg_en_o=0, ram_reg_rst_o=1.
  - rsp_data_o = ram_rdata_i, which is 0 once the RAM register has been reset.
  - Grant logic stays combinational: requests valid during reset may see req_ready_o, but no state updates.
  - Requesters must hold req_valid_i=0 while rst_ni=0.
- Reset mid-operation
  - In-flight reads are dropped; no rsp_valid_o for them after reset releases.
- Ignored inputs
  - A requester's we, addr and wdata are ignored when it is not granted.

Decomposition:
- Package bram_arb_pkg
  - Localparam ID_W = $clog2(NUM_REQ).
  - Typedef of the pipeline stage struct {valid, id}.
  - Function for one-hot-from-index.
- Sub-module rr_arbiter (NUM_REQ)
  - Inputs: valid vector and pointer. Output: one-hot grant plus index.
  - Purely combinational.
- Pointer register and read pipeline stay in the top.

Test Plan:
- Reset check: hold rst_ni=0 with requests idle for 3 cycles, then release → all rsp_valid_o=0, ram_en_o=0, ram_reg_rst_o=1 during reset, ptr=0.
- Single write then read: req0 writes addr 5, data 0xDEADBEEF, we=4'hF; next cycle req0 reads addr 5 → rsp_valid_o=4'b0001 exactly 2 cycles after the read accept, rsp_data_o=0xDEADBEEF.
- Byte write: write 0x11223344 to addr 7; req1 writes we=4'b0010, data 0x0000AA00; req1 reads addr 7 → 0x1122AA44 on rsp_valid_o=4'b0010.
- Round-robin fairness: all 4 requesters hold valid for 8 cycles → grant order 0,1,2,3,0,1,2,3, one grant per cycle.
- Back-to-back reads: req2 reads addr 1 and req3 reads addr 2 on consecutive cycles, after those addresses are preloaded with 0xA and 0xB → responses on consecutive cycles, 4'b0100/0xA then 4'b1000/0xB.
- Reset mid-flight: accept a read at T, drop rst_ni at T+1 for 1 cycle → no rsp_valid_o thereafter; the next read after reset returns normally with 2-cycle latency.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM port A arbiter.
// The stage id is sized for the largest supported requester count.
package bram_arb_pkg;

  localparam int NUM_REQ_MAX = 16;
  localparam int ID_W = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } stage_t;

  function automatic logic [NUM_REQ_MAX-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_REQ_MAX-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bram_port_a_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  int               j;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = PTR_W'(j);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/bram_port_a_arbiter.sv
// Shares RAM port A among NUM_REQ requesters, one access per cycle, and returns
// read data to the issuing requester two cycles after accept.
module bram_port_a_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_BITS  = 10,
  parameter int WORD_WIDTH = NB_COL * COL_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*NB_COL-1:0]       req_we_i,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr_i,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [WORD_WIDTH-1:0]           rsp_data_o,
  output logic                            ram_en_o,
  output logic [NB_COL-1:0]               ram_we_o,
  output logic [ADDR_BITS-1:0]            ram_addr_o,
  output logic [WORD_WIDTH-1:0]           ram_wdata_o,
  output logic                            ram_reg_en_o,
  output logic                            ram_reg_rst_o,
  input  logic [WORD_WIDTH-1:0]           ram_rdata_i
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]       ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W-1:0]       grant_idx;
  logic                   rd_acc_p0;
  stage_t                 stg_p1;
  stage_t                 stg_p2;
  logic [NUM_REQ_MAX-1:0] rsp_oh;
  logic                   unused_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid     (req_valid_i),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready_o   = grant;
  assign ram_en_o      = |grant;
  assign ram_reg_rst_o = ~rst_ni;

  always_comb begin
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ram_we_o    = req_we_i[i*NB_COL +: NB_COL];
        ram_addr_o  = req_addr_i[i*ADDR_BITS +: ADDR_BITS];
        ram_wdata_o = req_wdata_i[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign rd_acc_p0 = ram_en_o && (ram_we_o == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // p0 -> p1: accept cycle; RAM array register loads at this edge
  // p1 -> p2: output register loads while ram_reg_en_o is high
  always_ff @(posedge clk_i) begin
    stg_p1.id <= ID_W'(grant_idx);
    stg_p2.id <= stg_p1.id;
    if (!rst_ni) begin
      stg_p1.vld <= 1'b0;
      stg_p2.vld <= 1'b0;
    end else begin
      stg_p1.vld <= rd_acc_p0;
      stg_p2.vld <= stg_p1.vld;
    end
  end

  assign ram_reg_en_o = stg_p1.vld;

  // p2: RAM output register holds the data for the requester in stg_p2
  assign rsp_oh    = onehot(stg_p2.id);
  assign unused_oh = ^rsp_oh;

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_o[i] = stg_p2.vld & rsp_oh[i];
    end
  end

  assign rsp_data_o = ram_rdata_i;

endmodule
